timer_ctrl: RTL
===============

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, counter and period width in bits.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  begin counting, or resume from pause.
REQ-005 stop  input  1  pause counting.
REQ-006 load  input  1  write per_in into the period register.
REQ-007 per_in  input  WIDTH  period value.
REQ-008 mode  input  1  0 = one-shot, 1 = periodic; sampled when start is accepted from IDLE or DONE.
REQ-009 irq_ack  input  1  clears irq.
REQ-010 count  output  WIDTH  current counter value.
REQ-011 busy  output  1  high while in RUN.
REQ-012 tc  output  1  terminal-count strobe.
REQ-013 irq  output  1  sticky interrupt.
REQ-014 ovf_cnt  output  8  count of missed interrupts (see Configuration).

Function
REQ-015 The block SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-016 The block SHALL hold a period register PER, and count SHALL step 0..PER, giving a period of PER+1 cycles.
REQ-017 start in IDLE or DONE SHALL clear count to 0, latch mode and enter RUN at the next edge.
REQ-018 start in PAUSE SHALL enter RUN with count unchanged.
REQ-019 In RUN, count SHALL increment by 1 per cycle while count != PER.
REQ-020 tc SHALL be combinational, high exactly when state == RUN and count == PER.
REQ-021 On a tc cycle in periodic mode, count SHALL become 0 at the next edge and the block SHALL stay in RUN.
REQ-022 On a tc cycle in one-shot mode, count SHALL hold at PER and the block SHALL enter DONE.
REQ-023 PER == 0 SHALL produce tc on every RUN cycle in periodic mode, and one tc then DONE in one-shot mode.
REQ-024 stop in RUN SHALL enter PAUSE with count frozen; stop in any other state SHALL be ignored.
REQ-025 When start and stop are both high in the same cycle, stop SHALL win: RUN->PAUSE, PAUSE stays PAUSE, IDLE/DONE unchanged.
REQ-026 load SHALL update PER in IDLE, PAUSE or DONE, and SHALL be ignored in RUN.
REQ-027 If load is accepted in PAUSE with per_in < count, the counter SHALL run to 2^WIDTH-1, wrap to 0, then continue; no tc at the wrap.
REQ-028 irq SHALL be set at the edge following a tc cycle and SHALL stay high until an edge with irq_ack high.
REQ-029 When tc and irq_ack coincide, set SHALL win and irq SHALL remain 1.
REQ-030 count arithmetic SHALL be modulo 2^WIDTH.

Reset
REQ-031 RST high at an edge SHALL force IDLE, count = 0, PER = 0, latched mode = 0, irq = 0 and ovf_cnt = 0, overriding all other inputs.
REQ-032 RST asserted mid-RUN or mid-PAUSE SHALL abort the operation with no tc and no irq generated.
REQ-033 After reset, busy = 0 and tc = 0.

Configuration
REQ-034 With macro TIMER_OVF_CNT_EN defined, ovf_cnt SHALL increment on each tc cycle where irq is already 1 and irq_ack is 0, saturating at 8'hFF; it is cleared only by RST.
REQ-035 Without TIMER_OVF_CNT_EN, the ovf_cnt port SHALL exist and be tied to 8'h00, and no counter logic SHALL be synthesized.

Verification
REQ-036 RST 2 cycles, then load per_in=4, then start with mode=1 -> count 0,1,2,3,4,0,... with tc every 5th cycle and irq high one cycle after the first tc.
REQ-037 mode=0, PER=3, start -> tc once at count=3, then DONE, busy=0 and count holds 3; a second start restarts from 0.
REQ-038 Periodic PER=9; stop at count=6; hold 4 cycles; start -> count stays 6 during the pause, then resumes at 7 with no tc during the pause.
REQ-039 start+stop together in RUN -> PAUSE; load in RUN -> PER unchanged (tc still at the old value); irq_ack coincident with tc -> irq stays 1.
REQ-040 TIMER_OVF_CNT_EN defined, periodic PER=0, irq never acked for 300 cycles -> ovf_cnt saturates at 8'hFF; without the macro ovf_cnt = 0.
REQ-041 RST at count=5 in RUN -> next cycle IDLE, count=0, irq=0, PER=0.

Source files
------------

// File: rtl/timer_ctrl.sv
// Programmable up-counter timer with one-shot/periodic modes, pause/resume and a sticky irq.
// Optional missed-interrupt counter on ovf_cnt is built only when TIMER_OVF_CNT_EN is defined.
module timer_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] per_in,
  input  logic             mode,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             irq,
  output logic [7:0]       ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [WIDTH-1:0] per_q, per_nxt;
  logic             mode_q, mode_nxt;
  logic             irq_q;

  assign count = count_q;
  assign busy  = (state == RUN);
  assign tc    = (state == RUN) && (count_q == per_q);
  assign irq   = irq_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      count_q <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;
      per_q   <= per_nxt;
      mode_q  <= mode_nxt;
    end
  end

  // stop has priority over start in every state
  always_comb begin
    state_nxt = state;
    count_nxt = count_q;
    per_nxt   = per_q;
    mode_nxt  = mode_q;
    if (load && (state != RUN))
      per_nxt = per_in;
    case (state)
      IDLE, DONE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          count_nxt = '0;
          mode_nxt  = mode;
        end
      end
      PAUSE: begin
        if (start && !stop)
          state_nxt = RUN;
      end
      RUN: begin
        if (stop) begin
          state_nxt = PAUSE;
        end else if (tc) begin
          if (mode_q)
            count_nxt = '0;
          else
            state_nxt = DONE;
        end else begin
          // wraps modulo 2^WIDTH when PER was lowered below count
          count_nxt = count_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)
      irq_q <= 1'b0;
    else if (tc)
      irq_q <= 1'b1;
    else if (irq_ack)
      irq_q <= 1'b0;
  end

`ifdef TIMER_OVF_CNT_EN
  logic [7:0] ovf_q;

  always_ff @(posedge CLK) begin
    if (RST)
      ovf_q <= 8'h00;
    else if (tc && irq_q && !irq_ack && (ovf_q != 8'hFF))
      ovf_q <= ovf_q + 8'd1;
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 8'h00;
`endif

endmodule
